bram_writeback: RTL and testbench
=================================

# bram_writeback

Parametrised output write-back engine between the post-processing stages (matmul, norm, activation, pool) and an output BRAM port. It generalises the single-source, fixed-address output flop stage. It adds:
- a run-time source select among NUM_SRC streams;
- a programmable base address and stride;
- a per-lane write mask;
- a write count with a done pulse;
- a small FIFO that absorbs cycles where the BRAM port is not granted.

## Interface
Parameters:
- DWIDTH, 8, bits per element
- LANES, 4, elements per row (write-mask width equals LANES)
- AWIDTH, 10, BRAM address width
- NUM_SRC, 4, number of selectable producer streams
- FIFO_DEPTH, 4, row buffer depth (power of 2, ≥2)

Ports:
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-low; reset==0 at an edge clears all state
- start  in  1  one-cycle pulse; latches configuration, begins a run
- base_addr  in  AWIDTH  first write address
- addr_stride  in  AWIDTH  address increment per row
- num_rows  in  16  rows to write in this run
- src_sel  in  $clog2(NUM_SRC)  selected producer index
- lane_mask  in  LANES  per-lane write enable for the run
- src_valid  in  NUM_SRC  per-source row-valid strobe (no backpressure)
- src_data  in  NUM_SRC*LANES*DWIDTH  source i occupies slice i
- bram_ready  in  1  port grant; high in cycle t permits a write in cycle t+1
- bram_addr  out  AWIDTH  write address
- bram_wdata  out  LANES*DWIDTH  write data
- bram_we  out  LANES  per-lane write enable
- bram_en  out  1  equals |bram_we
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at end of run
- overflow  out  1  sticky; a row was dropped because the FIFO was full

## Operation
- All outputs reset to 0. The FIFO is emptied and the FSM enters IDLE.
- FSM states: IDLE, RUN, DONE.
  - IDLE→RUN on start. This latches base_addr, addr_stride, num_rows, src_sel and lane_mask, clears `overflow`, and zeroes the accepted and written counters.
  - IDLE→DONE on start with num_rows==0. No writes are issued.
  - RUN→DONE when written count reaches num_rows.
  - DONE→IDLE unconditionally after one cycle.
- start is ignored in RUN and DONE.
- Accept rule: in RUN, a row is pushed when src_valid[src_sel] is high and accepted count < num_rows.
  - The following are ignored: valid on other sources, valid in IDLE/DONE, and rows beyond num_rows.
- Full rule:
  - A push when full succeeds only if a pop occurs in the same cycle.
  - Otherwise the row is dropped, `overflow` is set, and the accepted count still increments so the run terminates.
  - A dropped row is never written; written count still advances for it (treated as skipped), and its address slot is skipped.
- Pop rule: pop when FIFO non-empty and bram_ready. In the next cycle the engine drives:
  - bram_we = lane_mask;
  - bram_addr = current address;
  - bram_wdata = row.
  
  Then current address += addr_stride, modulo 2^AWIDTH (wraps silently).
- bram_we is 0 in every cycle without a pop in the preceding cycle. bram_addr and bram_wdata hold their last values.
- lane_mask==0 still consumes rows and addresses. It produces no write-enables.

## Timing
- Latency: src_valid in cycle t with an empty FIFO and bram_ready high in t+1 gives bram_we asserted in cycle t+2.
- Throughput: one row per cycle sustained while bram_ready is high.
- busy is high from the cycle after start through the DONE cycle inclusive.
- done is high for the single DONE cycle, which is the cycle after the last write (or the cycle after start when num_rows==0).
- When bram_ready is low, pops stall. Up to FIFO_DEPTH rows are buffered, plus one more if a push and a pop coincide.
- A reset in mid-run aborts the run at that edge. From the next cycle: no writes, busy=0, done not pulsed.

## Structure
- Shared package:
  - default DWIDTH, LANES and AWIDTH values, matching the matmul block size;
  - FSM state enum {IDLE, RUN, DONE}.
- Sub-module `sync_fifo`:
  - parameters WIDTH and DEPTH;
  - first-word-fall-through;
  - push/pop/full/empty, with a simultaneous push and pop legal when full.
- The top-level source mux, counters, address generator and output register live in bram_writeback.

## Test plan
- Basic run: base 0x100, stride 4, num_rows 4, mask 0xF, src_sel 1, four consecutive valids on source 1, bram_ready=1 → writes at 0x100, 0x104, 0x108, 0x10C in cycles t+2..t+5; done in t+6; overflow 0.
- Source isolation: valids on sources 0, 2 and 3 interleaved with src_sel=2 → only source-2 rows are written, in order; the other sources are never written.
- Stall: num_rows 6, bram_ready low for 5 cycles during a 6-row burst, DEPTH 4 → 5 rows buffered, 1 dropped, overflow=1; 5 writes issued with addresses skipping the dropped slot; done pulses.
- Wrap: AWIDTH 10, base 0x3FC, stride 4, 3 rows → addresses 0x3FC, 0x000, 0x004.
- Edge configs:
  - num_rows 0 → done in the cycle after start, no bram_we;
  - start during RUN → ignored;
  - mask 0x5 → bram_we=0x5 on every write.
- Reset mid-run: reset=0 after 2 of 4 writes → bram_we=0, busy=0 the next cycle, no done; a fresh start then runs cleanly.

Source files
------------

// File: rtl/bram_writeback_pkg.sv
// bram_writeback_pkg: shared defaults (matmul block geometry) and FSM encoding for the write-back engine
package bram_writeback_pkg;
    localparam int DEF_DWIDTH = 8;
    localparam int DEF_LANES  = 4;
    localparam int DEF_AWIDTH = 10;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/bram_writeback_sync_fifo.sv
// sync_fifo: first-word-fall-through row buffer; push while full is taken when a pop coincides
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [PW:0] count;
    logic do_push, do_pop;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign full    = count == (PW+1)'(DEPTH);
    assign empty   = count == '0;
    assign dout    = mem[rd_ptr];
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/bram_writeback.sv
// bram_writeback: selects one producer stream, buffers rows and writes them to a BRAM port
// at base + k*stride, with per-lane mask, run count, done pulse and sticky overflow.
module bram_writeback
    import bram_writeback_pkg::*;
#(
    parameter int DWIDTH     = DEF_DWIDTH,
    parameter int LANES      = DEF_LANES,
    parameter int AWIDTH     = DEF_AWIDTH,
    parameter int NUM_SRC    = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic [AWIDTH-1:0]                 base_addr,
    input  logic [AWIDTH-1:0]                 addr_stride,
    input  logic [15:0]                       num_rows,
    input  logic [$clog2(NUM_SRC)-1:0]        src_sel,
    input  logic [LANES-1:0]                  lane_mask,
    input  logic [NUM_SRC-1:0]                src_valid,
    input  logic [NUM_SRC*LANES*DWIDTH-1:0]   src_data,
    input  logic                              bram_ready,
    output logic [AWIDTH-1:0]                 bram_addr,
    output logic [LANES*DWIDTH-1:0]           bram_wdata,
    output logic [LANES-1:0]                  bram_we,
    output logic                              bram_en,
    output logic                              busy,
    output logic                              done,
    output logic                              overflow
);
    localparam int RW = LANES * DWIDTH;
    state_t state, next_state;
    logic [AWIDTH-1:0] stride_r, push_addr;
    logic [15:0] rows_r, acc_cnt, wr_cnt;
    logic [$clog2(NUM_SRC)-1:0] sel_r;
    logic [LANES-1:0] mask_r;
    logic push_req, pop, drop, full, empty;
    logic [AWIDTH+RW-1:0] head;
    // Each row carries its own address so slots of dropped rows are skipped naturally.
    assign push_req = state == RUN && src_valid[sel_r] && acc_cnt < rows_r;
    assign pop      = !empty && bram_ready;
    assign drop     = push_req && full && !pop;
    assign busy     = state != IDLE;
    assign done     = state == DONE;
    assign bram_en  = |bram_we;
    sync_fifo #(.WIDTH(AWIDTH + RW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_req),
        .din   ({push_addr, src_data[RW*int'(sel_r) +: RW]}),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );
    always_comb begin
        next_state = state;
        if (state == IDLE && start) next_state = num_rows == 16'd0 ? DONE : RUN;
        else if (state == RUN && wr_cnt == rows_r) next_state = DONE;
        else if (state == DONE) next_state = IDLE;
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            stride_r   <= '0;
            push_addr  <= '0;
            rows_r     <= '0;
            acc_cnt    <= '0;
            wr_cnt     <= '0;
            sel_r      <= '0;
            mask_r     <= '0;
            bram_addr  <= '0;
            bram_wdata <= '0;
            bram_we    <= '0;
            overflow   <= 1'b0;
        end else begin
            state   <= next_state;
            bram_we <= pop ? mask_r : '0;
            if (pop) {bram_addr, bram_wdata} <= head;
            if (state == IDLE && start) begin
                stride_r  <= addr_stride;
                push_addr <= base_addr;
                rows_r    <= num_rows;
                sel_r     <= src_sel;
                mask_r    <= lane_mask;
                acc_cnt   <= '0;
                wr_cnt    <= '0;
                overflow  <= 1'b0;
            end else begin
                if (push_req) begin
                    acc_cnt   <= acc_cnt + 16'd1;
                    push_addr <= push_addr + stride_r;
                end
                if (pop || drop) wr_cnt <= wr_cnt + 16'd1;
                if (drop) overflow <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_bram_writeback.sv
// tb_bram_writeback: random and directed runs scored against a queue-based model of the engine
module tb_bram_writeback;
    localparam int DW = 8, L = 4, AW = 10, NS = 4, FD = 4, RW = L * DW;
    localparam int INF = 32'h7fffffff;

    logic clk = 1'b0, reset = 1'b0, start = 1'b0, bram_ready = 1'b0;
    logic [AW-1:0] base_addr = '0, addr_stride = '0;
    logic [15:0] num_rows = '0;
    logic [1:0] src_sel = '0;
    logic [L-1:0] lane_mask = '0;
    logic [NS-1:0] src_valid = '0;
    logic [NS*RW-1:0] src_data = '0;
    logic [AW-1:0] bram_addr;
    logic [RW-1:0] bram_wdata;
    logic [L-1:0] bram_we;
    logic bram_en, busy, done, overflow;

    bram_writeback #(.DWIDTH(DW), .LANES(L), .AWIDTH(AW), .NUM_SRC(NS), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .addr_stride(addr_stride),
        .num_rows(num_rows), .src_sel(src_sel), .lane_mask(lane_mask), .src_valid(src_valid),
        .src_data(src_data), .bram_ready(bram_ready), .bram_addr(bram_addr), .bram_wdata(bram_wdata),
        .bram_we(bram_we), .bram_en(bram_en), .busy(busy), .done(done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic [AW-1:0] a; logic [RW-1:0] d;} row_t;
    typedef struct packed {int c; logic [AW-1:0] a; logic [RW-1:0] d; logic [L-1:0] we;} wr_t;
    row_t fq[$];
    wr_t eq[$];
    int cyc = 0, s_cyc = -10, d_cyc = -5, acc = 0, events = 0, m_n = 0, m_sel = 0, cur;
    logic [AW-1:0] m_addr = '0, m_stride = '0;
    logic [L-1:0] m_mask = '0;
    logic m_ovf = 1'b0, m_pop, m_full;
    row_t m_row;
    int vectors = 0, miscompares = 0, wr_seen = 0;

    function automatic void chk(string name, longint act, longint want);
        vectors++;
        if (act != want) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, want, cyc);
        end
    endfunction

    // Reference model: a run is the interval (s_cyc, d_cyc]; rows are queued with their slot address.
    always @(posedge clk) begin
        cur = cyc;
        cyc++;
        if (!reset) begin
            fq.delete();
            eq.delete();
            s_cyc = -10;
            d_cyc = -5;
            m_ovf = 1'b0;
        end else begin
            m_full = fq.size() == FD;
            m_pop  = fq.size() > 0 && bram_ready;
            if (m_pop) begin
                m_row = fq.pop_front();
                if (m_mask != '0) eq.push_back('{c: cur + 1, a: m_row.a, d: m_row.d, we: m_mask});
                events++;
            end
            if (cur > s_cyc && cur < d_cyc && src_valid[m_sel] && acc < m_n) begin
                if (m_full && !m_pop) begin
                    m_ovf = 1'b1;
                    events++;
                end else fq.push_back('{a: m_addr, d: src_data[m_sel*RW +: RW]});
                acc++;
                m_addr = m_addr + m_stride;
            end
            if (d_cyc == INF && events == m_n) d_cyc = cur + 2;
            if (start && !(cur > s_cyc && cur <= d_cyc)) begin
                s_cyc = cur;
                d_cyc = num_rows == 16'd0 ? cur + 1 : INF;
                m_n = int'(num_rows);
                m_sel = int'(src_sel);
                m_mask = lane_mask;
                m_addr = base_addr;
                m_stride = addr_stride;
                acc = 0;
                events = 0;
                m_ovf = 1'b0;
            end
        end
    end

    // Monitor: every presented write is popped from the scoreboard and compared.
    always @(negedge clk) begin
        wr_t e;
        if (bram_en) begin
            wr_seen++;
            if (eq.size() == 0) chk("unexpected_write", bram_we, 0);
            else begin
                e = eq.pop_front();
                chk("wr_cycle", cyc, e.c);
                chk("wr_addr", bram_addr, e.a);
                chk("wr_data", bram_wdata, e.d);
                chk("wr_we", bram_we, e.we);
            end
        end else if (eq.size() > 0 && eq[0].c <= cyc) begin
            e = eq.pop_front();
            chk("missing_write", bram_we, e.we);
        end
        chk("done", done, cyc == d_cyc);
        chk("busy", busy, cyc > s_cyc && cyc <= d_cyc);
        chk("overflow", overflow, m_ovf);
    end

    task automatic step_d(logic [NS-1:0] v, logic r);
        for (int k = 0; k < NS * RW / 32; k++) src_data[k*32 +: 32] = $urandom;
        src_valid = v;
        bram_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic step(int vp, int rp);
        logic [NS-1:0] v;
        for (int i = 0; i < NS; i++) v[i] = $urandom_range(99) < vp;
        step_d(v, $urandom_range(99) < rp);
    endtask

    task automatic go(logic [AW-1:0] b, logic [AW-1:0] st, int n, int sel, logic [L-1:0] m);
        base_addr = b;
        addr_stride = st;
        num_rows = 16'(n);
        src_sel = 2'(sel);
        lane_mask = m;
        start = 1'b1;
        step_d('0, 1'b1);
        start = 1'b0;
    endtask

    task automatic wait_idle(string name);
        int k = 0;
        while (!((cyc > d_cyc || cyc <= s_cyc) && eq.size() == 0) && k < 300) begin
            step(50, 100);
            k++;
        end
        vectors++;
        if (k >= 300) begin
            miscompares++;
            $display("FAIL %s_timeout: run still active after %0d cycles, expected idle", name, k);
        end
    endtask

    initial begin
        int w0;
        repeat (3) step_d('0, 1'b0);
        chk("rst_we", bram_we, 0);
        chk("rst_en", bram_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ovf", overflow, 0);
        reset = 1'b1;
        step_d('0, 1'b0);

        w0 = wr_seen;
        go(10'h100, 10'd4, 4, 1, 4'hF);
        repeat (4) step_d(4'b0010, 1'b1);
        wait_idle("basic");
        chk("basic_writes", wr_seen - w0, 4);
        chk("basic_ovf", overflow, 0);

        go(10'h020, 10'd1, 6, 2, 4'hF);
        repeat (30) step(40, 100);
        wait_idle("isolation");

        w0 = wr_seen;
        go(10'h200, 10'd8, 6, 3, 4'hF);
        repeat (5) step_d(4'b1000, 1'b0);
        step_d(4'b1000, 1'b1);
        wait_idle("stall");
        chk("stall_writes", wr_seen - w0, 5);
        chk("stall_ovf", overflow, 1);

        w0 = wr_seen;
        go(10'h3FC, 10'd4, 3, 0, 4'hF);
        repeat (3) step_d(4'b0001, 1'b1);
        wait_idle("wrap");
        chk("wrap_writes", wr_seen - w0, 3);

        w0 = wr_seen;
        go(10'h010, 10'd1, 0, 0, 4'hF);
        repeat (4) step(100, 100);
        chk("zero_writes", wr_seen - w0, 0);

        w0 = wr_seen;
        go(10'h040, 10'd2, 5, 1, 4'hF);
        step_d(4'b0010, 1'b1);
        go(10'h300, 10'd7, 9, 3, 4'h3);
        repeat (4) step_d(4'b1010, 1'b1);
        wait_idle("restart");
        chk("restart_writes", wr_seen - w0, 5);

        go(10'h080, 10'd1, 4, 0, 4'h5);
        repeat (4) step_d(4'b0001, 1'b1);
        wait_idle("mask5");

        w0 = wr_seen;
        go(10'h090, 10'd1, 3, 0, 4'h0);
        repeat (3) step_d(4'b0001, 1'b1);
        wait_idle("mask0");
        chk("mask0_writes", wr_seen - w0, 0);

        w0 = wr_seen;
        go(10'h100, 10'd1, 4, 1, 4'hF);
        repeat (3) step_d(4'b0010, 1'b1);
        reset = 1'b0;
        step_d(4'b0010, 1'b1);
        reset = 1'b1;
        chk("rst_mid_we", bram_we, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_writes", wr_seen - w0, 2);
        repeat (4) step(50, 100);
        w0 = wr_seen;
        go(10'h180, 10'd3, 4, 2, 4'hF);
        repeat (4) step_d(4'b0100, 1'b1);
        wait_idle("post_reset");
        chk("post_reset_writes", wr_seen - w0, 4);

        for (int r = 0; r < 10; r++) begin
            int n = $urandom_range(12, 1);
            go(AW'($urandom), AW'($urandom), n, $urandom_range(NS - 1), L'($urandom));
            repeat (2 * n) step(70, 55);
            wait_idle("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end
endmodule
